// File: rtl/ex_operand_stage_pkg.sv
// Shared types for the 64-bit integer pipe: data word, ALU operation
// encoding, operand-select encodings and the decode-to-execute payload.
package ex_operand_stage_pkg;

   typedef logic [63:0] u64;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } ALU_CTR;

   typedef enum logic [1:0] {
      OPA_RS1  = 2'd0,
      OPA_PC   = 2'd1,
      OPA_ZERO = 2'd2
   } OPA_SEL;

   typedef enum logic [1:0] {
      OPB_RS2  = 2'd0,
      OPB_IMM  = 2'd1,
      OPB_FOUR = 2'd2
   } OPB_SEL;

   typedef struct packed {
      logic [4:0] rs1_idx;
      logic [4:0] rs2_idx;
      u64         rs1_val;
      u64         rs2_val;
      u64         pc;
      u64         imm;
      OPA_SEL     a_sel;
      OPB_SEL     b_sel;
      ALU_CTR     alu_ctrl;
      logic [4:0] rd;
      logic       wen;
   } ex_req_t;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Combinational bypass select for one source register.
// Ports: idx/rf_val (source index and register-file data), mem_* (MEM-stage
// producer), wb_* (WB-stage producer), fwd_val (resolved source value).
// x0 always reads zero; MEM beats WB; a MEM load has no data yet and is
// never forwarded (the top stalls on it instead).
module fwd_mux
   import ex_operand_stage_pkg::*;
(
   input  logic [4:0] idx,
   input  u64         rf_val,
   input  logic       mem_valid,
   input  logic [4:0] mem_rd,
   input  u64         mem_data,
   input  logic       mem_is_load,
   input  logic       wb_valid,
   input  logic [4:0] wb_rd,
   input  u64         wb_data,
   output u64         fwd_val
);

   always_comb begin
      fwd_val = rf_val;
      if (idx == 5'd0)
         fwd_val = '0;
      else if (mem_valid && (mem_rd == idx) && !mem_is_load)
         fwd_val = mem_data;
      else if (wb_valid && (wb_rd == idx))
         fwd_val = wb_data;
   end

endmodule

// File: rtl/ex_operand_stage.sv
// Decode-to-execute pipeline register with operand selection, MEM/WB
// forwarding and load-use stall.
// Ports: in_* (decode payload + valid/ready), mem_fwd_*/wb_fwd_* (producer
// buses), flush, out_valid/out_ready handshake to execute, and the
// registered payload data_a, data_b, ALU_ctrl, out_rd, out_wen.
module ex_operand_stage
   import ex_operand_stage_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [4:0] in_rs1_idx,
   input  logic [4:0] in_rs2_idx,
   input  u64         in_rs1_val,
   input  u64         in_rs2_val,
   input  u64         in_pc,
   input  u64         in_imm,
   input  OPA_SEL     in_a_sel,
   input  OPB_SEL     in_b_sel,
   input  ALU_CTR     in_alu_ctrl,
   input  logic [4:0] in_rd,
   input  logic       in_wen,
   input  logic       mem_fwd_valid,
   input  logic [4:0] mem_fwd_rd,
   input  u64         mem_fwd_data,
   input  logic       mem_fwd_is_load,
   input  logic       wb_fwd_valid,
   input  logic [4:0] wb_fwd_rd,
   input  u64         wb_fwd_data,
   input  logic       flush,
   output logic       out_valid,
   input  logic       out_ready,
   output u64         data_a,
   output u64         data_b,
   output ALU_CTR     ALU_ctrl,
   output logic [4:0] out_rd,
   output logic       out_wen
);

   ex_req_t    req;
   logic [4:0] src_idx [2];
   u64         src_rf  [2];
   u64         src_fwd [2];
   u64         opa_next;
   u64         opb_next;
   logic       rs1_used;
   logic       rs2_used;
   logic       hazard;
   logic       capture;

   assign req = '{rs1_idx: in_rs1_idx, rs2_idx: in_rs2_idx,
                  rs1_val: in_rs1_val, rs2_val: in_rs2_val,
                  pc: in_pc, imm: in_imm, a_sel: in_a_sel, b_sel: in_b_sel,
                  alu_ctrl: in_alu_ctrl, rd: in_rd, wen: in_wen};

   assign src_idx[0] = req.rs1_idx;
   assign src_idx[1] = req.rs2_idx;
   assign src_rf[0]  = req.rs1_val;
   assign src_rf[1]  = req.rs2_val;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         fwd_mux u_fwd_mux (
            .idx         (src_idx[gi]),
            .rf_val      (src_rf[gi]),
            .mem_valid   (mem_fwd_valid),
            .mem_rd      (mem_fwd_rd),
            .mem_data    (mem_fwd_data),
            .mem_is_load (mem_fwd_is_load),
            .wb_valid    (wb_fwd_valid),
            .wb_rd       (wb_fwd_rd),
            .wb_data     (wb_fwd_data),
            .fwd_val     (src_fwd[gi])
         );
      end
   endgenerate

   // Only a source that actually reaches the ALU can cause a load-use stall.
   assign rs1_used = (req.a_sel == OPA_RS1);
   assign rs2_used = (req.b_sel == OPB_RS2);
   assign hazard   = mem_fwd_valid && mem_fwd_is_load && (mem_fwd_rd != 5'd0) &&
                     ((rs1_used && (mem_fwd_rd == req.rs1_idx)) ||
                      (rs2_used && (mem_fwd_rd == req.rs2_idx)));

   assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
   assign capture  = in_valid && in_ready;

   always_comb begin
      opa_next = '0;
      case (req.a_sel)
         OPA_RS1: opa_next = src_fwd[0];
         OPA_PC:  opa_next = req.pc;
         default: opa_next = '0;
      endcase
   end

   always_comb begin
      opb_next = '0;
      case (req.b_sel)
         OPB_RS2:  opb_next = src_fwd[1];
         OPB_IMM:  opb_next = req.imm;
         OPB_FOUR: opb_next = 64'd4;
         default:  opb_next = '0;
      endcase
   end

   // flush is folded into in_ready, so capture is already blocked on flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         data_a    <= '0;
         data_b    <= '0;
         ALU_ctrl  <= ALU_ADD;
         out_rd    <= 5'd0;
         out_wen   <= 1'b0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (capture) begin
            out_valid <= 1'b1;
            data_a    <= opa_next;
            data_b    <= opb_next;
            ALU_ctrl  <= req.alu_ctrl;
            out_rd    <= req.rd;
            out_wen   <= req.wen;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;
   import ex_operand_stage_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] in_rs1_idx;
   logic [4:0] in_rs2_idx;
   u64         in_rs1_val;
   u64         in_rs2_val;
   u64         in_pc;
   u64         in_imm;
   OPA_SEL     in_a_sel;
   OPB_SEL     in_b_sel;
   ALU_CTR     in_alu_ctrl;
   logic [4:0] in_rd;
   logic       in_wen;
   logic       mem_fwd_valid;
   logic [4:0] mem_fwd_rd;
   u64         mem_fwd_data;
   logic       mem_fwd_is_load;
   logic       wb_fwd_valid;
   logic [4:0] wb_fwd_rd;
   u64         wb_fwd_data;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   u64         data_a;
   u64         data_b;
   ALU_CTR     ALU_ctrl;
   logic [4:0] out_rd;
   logic       out_wen;

   int checks = 0;
   int errors = 0;

   ex_operand_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
      .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
      .in_pc(in_pc), .in_imm(in_imm), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
      .in_alu_ctrl(in_alu_ctrl), .in_rd(in_rd), .in_wen(in_wen),
      .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd),
      .mem_fwd_data(mem_fwd_data), .mem_fwd_is_load(mem_fwd_is_load),
      .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .data_a(data_a), .data_b(data_b), .ALU_ctrl(ALU_ctrl),
      .out_rd(out_rd), .out_wen(out_wen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      u64         rs1_val;
      u64         rs2_val;
      u64         pc;
      u64         imm;
      OPA_SEL     a_sel;
      OPB_SEL     b_sel;
      ALU_CTR     alu;
      logic [4:0] rd;
      logic       wen;
      logic       mem_v;
      logic [4:0] mem_rd;
      u64         mem_data;
      logic       mem_ld;
      logic       wb_v;
      logic [4:0] wb_rd;
      u64         wb_data;
      u64         exp_a;
      u64         exp_b;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input u64 act, input u64 exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      in_rs1_idx      = v.rs1;
      in_rs2_idx      = v.rs2;
      in_rs1_val      = v.rs1_val;
      in_rs2_val      = v.rs2_val;
      in_pc           = v.pc;
      in_imm          = v.imm;
      in_a_sel        = v.a_sel;
      in_b_sel        = v.b_sel;
      in_alu_ctrl     = v.alu;
      in_rd           = v.rd;
      in_wen          = v.wen;
      mem_fwd_valid   = v.mem_v;
      mem_fwd_rd      = v.mem_rd;
      mem_fwd_data    = v.mem_data;
      mem_fwd_is_load = v.mem_ld;
      wb_fwd_valid    = v.wb_v;
      wb_fwd_rd       = v.wb_rd;
      wb_fwd_data     = v.wb_data;
   endtask

   // Simple PC/IMM instruction with no producers active.
   task automatic drive_pc_imm(input u64 pc, input u64 imm, input logic [4:0] rd);
      vec_t v;
      v = '{5'd0, 5'd0, 64'd0, 64'd0, pc, imm, OPA_PC, OPB_IMM, ALU_ADD, rd, 1'b1,
            1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0};
      drive(v);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{5'd5, 5'd0, 64'h1111, 64'h0, 64'h0, 64'h10, OPA_RS1, OPB_IMM, ALU_SUB, 5'd7, 1'b1,
                  1'b1, 5'd5, 64'h1234, 1'b0, 1'b1, 5'd5, 64'hFFFF, 64'h1234, 64'h10};
      vecs[1] = '{5'd5, 5'd9, 64'h1111, 64'h99, 64'h0, 64'h0, OPA_RS1, OPB_RS2, ALU_AND, 5'd8, 1'b1,
                  1'b1, 5'd6, 64'hDEAD, 1'b0, 1'b1, 5'd5, 64'hFFFF, 64'hFFFF, 64'h99};
      vecs[2] = '{5'd0, 5'd0, 64'h55, 64'h0, 64'h0, 64'h0, OPA_RS1, OPB_FOUR, ALU_OR, 5'd1, 1'b1,
                  1'b1, 5'd0, 64'h7, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h4};
      vecs[3] = '{5'd0, 5'd0, 64'h0, 64'h0, 64'h8000_0000, 64'h0, OPA_PC, OPB_FOUR, ALU_ADD, 5'd1, 1'b1,
                  1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h8000_0000, 64'h4};
      vecs[4] = '{5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, OPA_ZERO, OPB_IMM, ALU_XOR, 5'd31, 1'b0,
                  1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[5] = '{5'd4, 5'd3, 64'h44, 64'h33, 64'h0, 64'h20, OPA_RS1, OPB_IMM, ALU_SLT, 5'd10, 1'b1,
                  1'b1, 5'd3, 64'hBAD, 1'b1, 1'b0, 5'd0, 64'h0, 64'h44, 64'h20};
      vecs[6] = '{5'd0, 5'd2, 64'h0, 64'h22, 64'h0, 64'h0, OPA_RS1, OPB_RS2, ALU_SRA, 5'd12, 1'b1,
                  1'b1, 5'd0, 64'h77, 1'b1, 1'b1, 5'd2, 64'h2222, 64'h0, 64'h2222};
      vecs[7] = '{5'd3, 5'd4, 64'h3, 64'h4, 64'h40, 64'h0, OPA_PC, OPB_RS2, ALU_ADD, 5'd0, 1'b0,
                  1'b1, 5'd3, 64'h5, 1'b1, 1'b0, 5'd0, 64'h0, 64'h40, 64'h4};

      // Reset and idle
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      drive_pc_imm(64'h0, 64'h0, 5'd0);
      #2;
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset data_a", data_a, 64'd0);
      chk("reset data_b", data_b, 64'd0);
      chk("reset ALU_ctrl", 64'(ALU_ctrl), 64'(ALU_ADD));
      chk("reset out_rd", 64'(out_rd), 64'd0);
      chk("reset out_wen", 64'(out_wen), 64'd0);
      #10 rst_n = 1'b1;
      step();
      chk("idle out_valid", 64'(out_valid), 64'd0);

      // Table-driven, back-to-back with out_ready=1
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i]);
         in_valid = 1'b1;
         #1;
         chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'd1);
         step();
         chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("vec%0d data_a", i), data_a, vecs[i].exp_a);
         chk($sformatf("vec%0d data_b", i), data_b, vecs[i].exp_b);
         chk($sformatf("vec%0d ALU_ctrl", i), 64'(ALU_ctrl), 64'(vecs[i].alu));
         chk($sformatf("vec%0d out_rd", i), 64'(out_rd), 64'(vecs[i].rd));
         chk($sformatf("vec%0d out_wen", i), 64'(out_wen), 64'(vecs[i].wen));
         $display("vec%0d a=0x%0h b=0x%0h", i, data_a, data_b);
      end

      // Load-use on rs2: one bubble, then WB supplies the loaded value
      drive_pc_imm(64'h0, 64'h0, 5'd6);
      in_b_sel = OPB_RS2; in_rs2_idx = 5'd3; in_rs2_val = 64'h1;
      mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_is_load = 1'b1; mem_fwd_data = 64'hBAD;
      #1;
      chk("loaduse in_ready", 64'(in_ready), 64'd0);
      step();
      chk("loaduse bubble", 64'(out_valid), 64'd0);
      mem_fwd_valid = 1'b0; wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd3; wb_fwd_data = 64'hAB;
      #1;
      chk("loaduse resume in_ready", 64'(in_ready), 64'd1);
      step();
      chk("loaduse out_valid", 64'(out_valid), 64'd1);
      chk("loaduse data_b", data_b, 64'hAB);
      $display("loaduse data_b=0x%0h", data_b);

      // Back-pressure: hold X for 3 cycles while Y waits
      drive_pc_imm(64'h111, 64'h222, 5'd11);
      step();
      out_ready = 1'b0;
      drive_pc_imm(64'h333, 64'h444, 5'd13);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("bp%0d in_ready", c), 64'(in_ready), 64'd0);
         step();
         chk($sformatf("bp%0d out_valid", c), 64'(out_valid), 64'd1);
         chk($sformatf("bp%0d data_a", c), data_a, 64'h111);
         chk($sformatf("bp%0d data_b", c), data_b, 64'h222);
         chk($sformatf("bp%0d out_rd", c), 64'(out_rd), 64'd11);
      end
      out_ready = 1'b1;
      #1;
      chk("bp release in_ready", 64'(in_ready), 64'd1);
      step();
      chk("bp swap out_valid", 64'(out_valid), 64'd1);
      chk("bp swap data_a", data_a, 64'h333);
      chk("bp swap out_rd", 64'(out_rd), 64'd13);
      in_valid = 1'b0;
      step();
      chk("bp drain out_valid", 64'(out_valid), 64'd0);
      $display("backpressure done data_a=0x%0h", data_a);

      // Flush with in_valid and out_valid both high
      in_valid = 1'b1;
      drive_pc_imm(64'h500, 64'h0, 5'd5);
      step();
      drive_pc_imm(64'h600, 64'h0, 5'd6);
      flush = 1'b1;
      #1;
      chk("flush in_ready", 64'(in_ready), 64'd0);
      step();
      chk("flush out_valid", 64'(out_valid), 64'd0);
      chk("flush no capture", data_a, 64'h500);
      flush = 1'b0;
      step();
      chk("post-flush out_valid", 64'(out_valid), 64'd1);
      chk("post-flush data_a", data_a, 64'h600);
      $display("flush done data_a=0x%0h", data_a);

      // Reset mid-stall drops the held entry asynchronously
      out_ready = 1'b0;
      drive_pc_imm(64'h700, 64'h0, 5'd7);
      step();
      chk("stall hold out_valid", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset out_valid", 64'(out_valid), 64'd0);
      chk("midreset data_a", data_a, 64'd0);
      chk("midreset out_rd", 64'(out_rd), 64'd0);
      $display("midreset done");
      #4 rst_n = 1'b1;
      in_valid = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

Decode-to-execute pipeline register for the 64-bit integer pipe. It accepts a decoded instruction from decode over a valid/ready handshake and selects the two ALU operands from register-file values, PC or immediate. It resolves RAW hazards by forwarding from the MEM and WB stages and by stalling on load-use. The registered operands and ALU control feed the combinational ALU directly.

## Interface
Parameters:
- none (widths fixed by common package: u64 data, 5-bit register index)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle (combinational)
- in_rs1_idx, in_rs2_idx  in  5 each  source register indices
- in_rs1_val, in_rs2_val  in  u64 each  register-file read data
- in_pc  in  u64  instruction PC
- in_imm  in  u64  sign-extended immediate
- in_a_sel  in  OPA_SEL  operand A source: OPA_RS1, OPA_PC, OPA_ZERO
- in_b_sel  in  OPB_SEL  operand B source: OPB_RS2, OPB_IMM, OPB_FOUR
- in_alu_ctrl  in  ALU_CTR  operation for execute
- in_rd  in  5  destination index
- in_wen  in  1  instruction writes rd
- mem_fwd_valid, mem_fwd_rd, mem_fwd_data, mem_fwd_is_load  in  1/5/u64/1  MEM-stage producer
- wb_fwd_valid, wb_fwd_rd, wb_fwd_data  in  1/5/u64  WB-stage producer
- flush  in  1  kill the held instruction and any capture this cycle
- out_valid  out  1  data_a/data_b/ALU_ctrl are valid for execute
- out_ready  in  1  execute consumes this cycle
- data_a, data_b  out  u64 each  registered ALU operands
- ALU_ctrl  out  ALU_CTR  registered ALU operation
- out_rd  out  5  registered destination
- out_wen  out  1  registered write enable

## Operation
- Forwarded source for rsN (N=1,2): if rsN_idx==0, use 0. Else if mem_fwd_valid and mem_fwd_rd==rsN_idx and !mem_fwd_is_load, use mem_fwd_data. Else if wb_fwd_valid and wb_fwd_rd==rsN_idx, use wb_fwd_data. Else use in_rsN_val.
- MEM has priority over WB.
- Load-use hazard: mem_fwd_valid && mem_fwd_is_load && mem_fwd_rd!=0 && the rd matches a source actually used. rs1 is used iff a_sel==OPA_RS1; rs2 is used iff b_sel==OPB_RS2.
- Operand A: OPA_RS1 gives fwd rs1, OPA_PC gives in_pc, OPA_ZERO gives 0.
- Operand B: OPB_RS2 gives fwd rs2, OPB_IMM gives in_imm, OPB_FOUR gives 64'd4.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Capture: on in_valid && in_ready, load data_a, data_b, ALU_ctrl, out_rd, out_wen, and set out_valid=1.
- Drain: out_valid && out_ready && no capture sets out_valid=0.
- Held entry: while out_valid && !out_ready, all outputs are stable. Producers upstream of execute are stalled too, so no re-forwarding is needed.
- flush: next cycle out_valid=0, and no capture occurs that cycle regardless of in_valid. The payload registers keep their values and are don't-care.
- A bubble (out_valid=0) never asserts out_wen to consumers. Consumers qualify out_wen with out_valid.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, data_a=0, data_b=0, ALU_ctrl=ADD, out_rd=0, out_wen=0.
- Latency: 1 cycle from accepted handshake to out_valid.
- Throughput: 1 instruction/cycle while out_ready=1 and there is no hazard.
- Back-to-back: when out_valid=1, out_ready=1 and in_valid=1 in the same cycle, the old entry drains and the new one loads in that same edge, so out_valid stays 1.
- A hazard inserts exactly one bubble per cycle it persists. Decode must hold its inputs stable while in_ready=0.
- Simultaneous flush and out_ready: flush wins, and out_valid goes to 0.
- Reset mid-stall drops the held entry immediately.

## Structure
- common package gets: OPA_SEL and OPB_SEL enums, and an ex_req_t struct bundling the decode payload (indices, values, pc, imm, selects, alu_ctrl, rd, wen).
- It reuses the existing u64 and ALU_CTR types.
- One sub-module: fwd_mux, instantiated twice (rs1, rs2). It is combinational and takes idx, rf value and both producer buses, and outputs the forwarded value. The load-use compare lives in the top.

## Test plan
- Reset then idle: rst_n low mid-cycle. Outputs go to 0/ADD immediately, and out_valid=0 until the first handshake.
- ALU-ALU forward: MEM producer rd=5 with data 0x1234, rs1=5, a_sel=RS1, WB producer rd=5 with data 0xFFFF. Next cycle data_a=0x1234 (MEM priority).
- x0 and select paths:
  - rs1=0 with MEM rd=0, data 7: data_a=0.
  - a_sel=PC, pc=0x8000_0000, b_sel=FOUR: data_a=0x8000_0000, data_b=4.
- Load-use: MEM is_load with rd=3, rs2=3, b_sel=RS2. in_ready=0 for one cycle, and a bubble appears. Next cycle, WB rd=3 with data 0xAB gives data_b=0xAB. With b_sel=IMM instead, there is no stall.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1. Outputs stay stable and in_ready=0. When out_ready=1, the old entry drains and the new one loads in the same edge.
- Flush: flush together with in_valid=1 and out_valid=1. The next cycle has out_valid=0 and nothing captured. The cycle after, normal capture resumes.
